// File: rtl/data_memory_be_if.sv
// data_memory_be_if: access bus of the byte-enabled data memory (master = datapath, slave = memory)
interface data_memory_be_if #(parameter int ADDR_W = 32);
  logic              en;
  logic              we;
  logic [1:0]        size;
  logic              signed_ld;
  logic [ADDR_W-1:0] a;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic              rd_valid;
  logic              misalign;
  logic              busy;
  modport master (output en, we, size, signed_ld, a, wd, input rd, rd_valid, misalign, busy);
  modport slave  (input en, we, size, signed_ld, a, wd, output rd, rd_valid, misalign, busy);
endinterface

// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressed, byte-enabled data memory with registered loads and post-reset clear sweep
// Ports: clk (rising edge), rst_n (async, active-low), bus (slave side of data_memory_be_if:
// en/we/size/signed_ld/a/wd in; rd/rd_valid/misalign/busy out)
module data_memory_be #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  data_memory_be_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef enum logic {INIT, READY} state_t;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_q, rd_d;
  logic              rd_valid_q, misalign_q;
  logic [31:0]       mem_q [DEPTH];
  logic [IDX_W-1:0]  idx, w_idx;
  logic [1:0]        lane;
  logic              busy, acc, illegal, st, ld, w_en;
  logic [3:0]        be, w_be;
  logic [31:0]       st_dat, w_dat, word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              unused_hi;
  assign unused_hi = ^bus.a[ADDR_W-1:IDX_W+2];
  assign idx  = bus.a[IDX_W+1:2];
  assign lane = bus.a[1:0];
  assign busy = state_q == INIT;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == IDX_W'(DEPTH - 1) ? READY : INIT;
    end
  end
  assign acc     = bus.en && state_q == READY;
  assign illegal = bus.size == 2'b11 || (bus.size == 2'b01 && lane[0]) || (bus.size == 2'b10 && lane != 2'b00);
  assign st      = acc && bus.we && !illegal;
  assign ld      = acc && !bus.we && !illegal;
  // store data is replicated across lanes so the byte enables alone pick the target bytes
  assign be     = bus.size == 2'b00 ? 4'b0001 << lane : bus.size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_dat = bus.size == 2'b00 ? {4{bus.wd[7:0]}} : bus.size == 2'b01 ? {2{bus.wd[15:0]}} : bus.wd;
  // the clear sweep and datapath stores share the single write port
  assign w_en  = busy || st;
  assign w_idx = busy ? cnt_q : idx;
  assign w_be  = busy ? 4'b1111 : be;
  assign w_dat = busy ? 32'd0 : st_dat;
  assign word    = mem_q[idx];
  assign ld_byte = word[8*lane +: 8];
  assign ld_half = lane[1] ? word[31:16] : word[15:0];
  assign rd_d = !ld ? rd_q :
                bus.size == 2'b00 ? {{24{bus.signed_ld & ld_byte[7]}}, ld_byte} :
                bus.size == 2'b01 ? {{16{bus.signed_ld & ld_half[15]}}, ld_half} : word;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_en && w_be[i]) mem_q[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      rd_valid_q <= ld;
      misalign_q <= acc && illegal;
    end
  end
  assign bus.rd       = rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.misalign = misalign_q;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: table-driven scoreboard bench for data_memory_be
module tb_data_memory_be;
  localparam int DEPTH = 256;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        v;
    logic        m;
    logic        en;
  } vec_t;
  typedef struct {
    logic [31:0] rd;
    logic        v;
    logic        m;
    int          id;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] last_rd = 32'd0;
  vec_t vt[$];
  exp_t sb[$];
  data_memory_be_if #(.ADDR_W(32)) bus ();
  data_memory_be #(.DEPTH(DEPTH), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(logic en, logic we, logic [1:0] size, logic sgn, logic [31:0] a,
                              logic [31:0] wd, logic v, logic m, logic [31:0] rd);
    vec_t x;
    x.en = en; x.we = we; x.size = size; x.sgn = sgn; x.a = a; x.wd = wd; x.v = v; x.m = m; x.rd = rd;
    return x;
  endfunction
  task automatic drive(input logic en, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.en = en; bus.we = we; bus.size = size; bus.signed_ld = sgn; bus.a = a; bus.wd = wd;
  endtask
  task automatic apply(input vec_t x, input int id);
    exp_t e;
    exp_t g;
    drive(x.en, x.we, x.size, x.sgn, x.a, x.wd);
    if (x.v) last_rd = x.rd;
    e.rd = last_rd; e.v = x.v; e.m = x.m; e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk($sformatf("v%0d_rd", g.id), bus.rd, g.rd);
    chk($sformatf("v%0d_valid", g.id), {31'd0, bus.rd_valid}, {31'd0, g.v});
    chk($sformatf("v%0d_mis", g.id), {31'd0, bus.misalign}, {31'd0, g.m});
  endtask
  task automatic count_busy(input string nm);
    int n = 0;
    while (bus.busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, DEPTH);
  endtask
  initial begin
    int seen_v;
    bus.en = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.signed_ld = 1'b0; bus.a = '0; bus.wd = '0;
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h000, 0, 1, 0, 32'h0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h3FC, 0, 1, 0, 32'h0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h200, 0, 1, 0, 32'h0));
    vt.push_back(mk(1, 1, 2'b10, 0, 32'h010, 32'h8899AABB, 0, 0, 0));
    vt.push_back(mk(1, 0, 2'b00, 1, 32'h013, 0, 1, 0, 32'hFFFFFF88));
    vt.push_back(mk(1, 0, 2'b00, 0, 32'h010, 0, 1, 0, 32'h000000BB));
    vt.push_back(mk(1, 0, 2'b01, 1, 32'h012, 0, 1, 0, 32'hFFFF8899));
    vt.push_back(mk(1, 0, 2'b01, 0, 32'h012, 0, 1, 0, 32'h00008899));
    vt.push_back(mk(1, 0, 2'b10, 1, 32'h010, 0, 1, 0, 32'h8899AABB));
    vt.push_back(mk(1, 1, 2'b10, 0, 32'h020, 32'h11223344, 0, 0, 0));
    vt.push_back(mk(1, 1, 2'b00, 0, 32'h021, 32'h000000EE, 0, 0, 0));
    vt.push_back(mk(1, 1, 2'b01, 0, 32'h022, 32'h0000CAFE, 0, 0, 0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h020, 0, 1, 0, 32'hCAFEEE44));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h002, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 2'b01, 0, 32'h005, 32'h0000FFFF, 0, 1, 0));
    vt.push_back(mk(1, 1, 2'b11, 0, 32'h020, 32'h0, 0, 1, 0));
    vt.push_back(mk(1, 0, 2'b11, 0, 32'h010, 0, 0, 1, 0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h004, 0, 1, 0, 32'h0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h020, 0, 1, 0, 32'hCAFEEE44));
    vt.push_back(mk(0, 0, 2'b10, 0, 32'h020, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 2'b00, 1, 32'h021, 0, 1, 0, 32'hFFFFFFEE));
    vt.push_back(mk(1, 0, 2'b01, 0, 32'h022, 0, 1, 0, 32'h0000CAFE));
    vt.push_back(mk(1, 0, 2'b01, 1, 32'h020, 0, 1, 0, 32'hFFFFEE44));
    vt.push_back(mk(1, 0, 2'b00, 0, 32'h022, 0, 1, 0, 32'h000000FE));
    vt.push_back(mk(1, 1, 2'b10, 0, 32'h400, 32'h12345678, 0, 0, 0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h000, 0, 1, 0, 32'h12345678));
    vt.push_back(mk(1, 0, 2'b01, 1, 32'h001, 0, 0, 1, 0));
    #1;
    chk("rst_rd", bus.rd, 0);
    chk("rst_valid", {31'd0, bus.rd_valid}, 0);
    chk("rst_mis", {31'd0, bus.misalign}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy("busy_len0");
    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);
    apply(mk(1, 1, 2'b10, 0, 32'h320, 32'hDEADBEEF, 0, 0, 0), 100);
    apply(mk(1, 0, 2'b10, 0, 32'h320, 0, 1, 0, 32'hDEADBEEF), 101);
    @(negedge clk);
    bus.en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, bus.busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", bus.rd, 0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 1);
    @(negedge clk);
    bus.en = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.a = 32'h320; bus.wd = 32'h55555555;
    rst_n = 1'b1;
    seen_v = 0;
    begin
      int n = 0;
      while (bus.busy && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
        seen_v |= int'(bus.rd_valid) | int'(bus.misalign);
        if (n == 150) bus.we = 1'b0;
      end
      chk("busy_len1", n, DEPTH);
    end
    chk("busy_quiet", seen_v, 0);
    last_rd = 32'd0;
    apply(mk(1, 0, 2'b10, 0, 32'h320, 0, 1, 0, 32'h0), 102);
    apply(mk(1, 0, 2'b10, 0, 32'h000, 0, 1, 0, 32'h0), 103);
    apply(mk(1, 0, 2'b10, 0, 32'h020, 0, 1, 0, 32'h0), 104);
    @(negedge clk);
    bus.en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
